// File: rtl/piso_shiftout_if.sv
// piso_shiftout_if: word-load handshake plus serial output bundle for piso_shiftout.
//   slave  modport: the transmitter (consumes D/L, drives rdy/SO/SV/last).
//   master modport: the word producer / serial consumer side.
interface piso_shiftout_if #(
  parameter int W = 4
);
  logic [W-1:0] D;
  logic         L;
  logic         rdy;
  logic         SO;
  logic         SV;
  logic         last;

  modport slave (
    input  D,
    input  L,
    output rdy,
    output SO,
    output SV,
    output last
  );

  modport master (
    output D,
    output L,
    input  rdy,
    input  SO,
    input  SV,
    input  last
  );
endinterface

// File: rtl/piso_shiftout.sv
// piso_shiftout: parallel-in, serial-out transmitter with valid/last framing.
// Optional feature macro: PISO_PARITY_EN (appends an even-parity bit, N = W+1).
//
// Handshake: a word is accepted on a rising edge of C where E=1, L=1 and rdy=1.
// rdy is combinational from state (high when idle, or on the final bit of a
// frame so the next word can load gaplessly). L while rdy=0 is ignored and D is
// don't-care whenever no load is accepted. SV qualifies SO; last marks the
// final bit of each frame. Nothing changes on edges with E=0.
module piso_shiftout #(
  parameter int W         = 4,
  parameter int MSB_FIRST = 0
) (
  input  logic                C,
  input  logic                aRn,
  input  logic                E,
  piso_shiftout_if.slave      bus,
  output logic                state_dbg
);

`ifdef PISO_PARITY_EN
  localparam int N = W + 1;
`else
  localparam int N = W;
`endif
  localparam int CW = $clog2(W + 1);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    sr_q, sr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            so_q, so_d;
  logic            sv_q, sv_d;
  logic            last_q, last_d;
  logic            rdy;
`ifdef PISO_PARITY_EN
  logic            par_q, par_d;
`endif

  assign rdy       = (state_q == IDLE) | ((state_q == SHIFT) & last_q);
  assign bus.rdy   = rdy;
  assign bus.SO    = so_q;
  assign bus.SV    = sv_q;
  assign bus.last  = last_q;
  assign state_dbg = (state_q == SHIFT);

  // Next-state and datapath: load, advance one bit, or close the frame.
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    so_d    = so_q;
    sv_d    = sv_q;
    last_d  = last_q;
`ifdef PISO_PARITY_EN
    par_d   = par_q;
`endif
    if (E) begin
      if (bus.L && rdy) begin
        // Accept a word: first bit goes straight to SO, the rest wait in sr.
        state_d = SHIFT;
        cnt_d   = '0;
        sv_d    = 1'b1;
        last_d  = 1'b0;
        if (MSB_FIRST != 0) begin
          so_d = bus.D[W-1];
          sr_d = {bus.D[W-2:0], 1'b0};
        end else begin
          so_d = bus.D[0];
          sr_d = {1'b0, bus.D[W-1:1]};
        end
`ifdef PISO_PARITY_EN
        par_d = ^bus.D;
`endif
      end else if (state_q == SHIFT) begin
        if (last_q) begin
          // Frame done with no follow-on word: drop framing and go idle.
          state_d = IDLE;
          cnt_d   = '0;
          so_d    = 1'b0;
          sv_d    = 1'b0;
          last_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + CW'(1);
          if (MSB_FIRST != 0) begin
            so_d = sr_q[W-1];
            sr_d = {sr_q[W-2:0], 1'b0};
          end else begin
            so_d = sr_q[0];
            sr_d = {1'b0, sr_q[W-1:1]};
          end
`ifdef PISO_PARITY_EN
          // After the last data bit the parity bit is presented.
          if (cnt_q == CW'(W - 1)) begin
            so_d = par_q;
          end
`endif
          last_d = (cnt_d == CW'(N - 1));
        end
      end
    end
  end

  // State and datapath registers; reset discards any frame in flight.
  always_ff @(posedge C or negedge aRn) begin
    if (!aRn) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      so_q    <= 1'b0;
      sv_q    <= 1'b0;
      last_q  <= 1'b0;
`ifdef PISO_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      so_q    <= so_d;
      sv_q    <= sv_d;
      last_q  <= last_d;
`ifdef PISO_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

endmodule

// File: doc/piso_shiftout.md
# piso_shiftout

Parallel-in, serial-out transmitter that complements the team's parallel-load register: it accepts a W-bit word through a load/ready handshake and shifts it out one bit per enabled clock, with valid and last-bit framing. It sits between a word-wide producer and a single-wire serial consumer. It supports back-to-back words with no idle gap, and a clock-enable input paces the output (baud tick).

## Interface
- W, default 4: parallel word width, must be ≥ 2.
- MSB_FIRST, default 0: 0 = bit 0 shifted first, 1 = bit W-1 shifted first.

- C  in  1  clock, rising edge.
- aRn  in  1  reset, asynchronous, active-low.
- E  in  1  shift enable; all state changes occur only on edges with E=1.
- D  in  W  parallel data word, sampled on an accepted load.
- L  in  1  load request.
- rdy  out  1  load can be accepted this cycle; combinational from state.
- SO  out  W=1  serial data, registered.
- SV  out  1  SO valid, registered.
- last  out  1  current SO is the final bit of the frame, registered.

## Operation
- Frame length N = W. With PISO_PARITY_EN, N = W+1.
- Internal state: W-bit shift register, bit counter of width $clog2(W+1), and a 2-state FSM (IDLE, SHIFT).
- rdy = (state==IDLE) | (state==SHIFT & last).
- Load is accepted on an edge with aRn=1, E=1, L=1 and rdy=1. D is captured, SV goes to 1, the counter goes to 0, state goes to SHIFT, and the first bit drives SO.
- L while rdy=0 is ignored and has no side effects. D is don't-care when no load is accepted.
- In SHIFT, each E=1 edge with last=0 advances one bit and increments the counter. last=1 exactly when the counter equals N-1.
- E=1 edge with last=1:
  - L=1: the next word loads on the same edge, giving a gapless stream.
  - L=0: SV, SO and last go to 0, and state goes to IDLE.
- E=0: every register holds, and SO, SV and last stay stable. rdy still reflects state.
- Reset (aRn=0), at any time including mid-frame:
  - SO=0, SV=0, last=0, counter=0, shift register=0, state=IDLE.
  - rdy=1 while in reset.
  - The word being shifted is discarded, and no partial frame resumes.
- Reset release: the first E=1 edge after aRn rises may accept a load.

## Timing
- Load latency: the first bit appears on SO/SV immediately after the accepting edge, which is 0 cycles of added delay.
- Frame occupies exactly N enabled cycles. With E tied high, SV stays high N cycles per word.
- With L held high and E=1, throughput is 1 bit/cycle. SV never drops between words.
- Bit order at E=1 edge k after load, for k = 0..W-1:
  - MSB_FIRST=0: SO = D[k].
  - MSB_FIRST=1: SO = D[W-1-k].
- Parity bit, when enabled, is the last bit (k=W) and equals ^D (even parity). The data bits are unchanged.

## Configuration
- PISO_PARITY_EN defined: N = W+1, and an even-parity bit is appended after the data bits with last asserted on it.
- PISO_PARITY_EN undefined: N = W, no parity logic exists, and last is asserted on the final data bit.

## Test plan
- Reset values: aRn=0 mid-frame (after 2 bits of D=4'b1011) -> SO=0, SV=0, last=0, rdy=1 asynchronously. After release there are no stray SV pulses.
- Single word, W=4, MSB_FIRST=0, E=1, D=4'b1011 loaded -> SO = 1,1,0,1 with SV=1 for 4 cycles and last=1 on the 4th; rdy=0 on cycles 1–3. With PISO_PARITY_EN: 1,1,0,1,1 with last on the 5th.
- MSB_FIRST=1, D=4'b1011 -> SO = 1,0,1,1.
- Back-to-back: L held high, D=4'b0001 then 4'b1000 -> SO 1,0,0,0,0,0,0,1 with SV continuously 1 for 8 cycles and last pulsed on cycles 4 and 8.
- Enable stall: E toggled 1,0,0,1 during a frame -> SO/SV/last hold through the E=0 cycles and the frame completes after 4 enabled edges.
- Load while busy: L pulsed with D=4'hF on cycle 2 of a frame of 4'h0 -> ignored; the output is 0,0,0,0 and then SV=0.
